// File: rtl/inst_fetch_align_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetch_align_pkg : fetch FSM states, RVC length constant, byte swap    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package inst_fetch_align_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    // Low two bits of a 32-bit (non-compressed) instruction.
    localparam logic [1:0] c_rvc_quad32 = 2'b11;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_align_hw_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetch_align_hw_queue : circular halfword queue, push/pop 1-2 per cycle|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_fetch_align_hw_queue #(
    parameter int BUF_HW = 4
) (
    input  logic                    Clk_i,
    input  logic                    Rst_i,
    input  logic                    Flush_i,
    input  logic [1:0]              PushN_i,
    input  logic [31:0]             PushData_i,
    input  logic [1:0]              PopN_i,
    output logic [$clog2(BUF_HW):0] Count_o,
    output logic [15:0]             Head0_o,
    output logic [15:0]             Head1_o
);
    localparam int PW = $clog2(BUF_HW);
    localparam int CW = PW + 1;

    logic [15:0]   mem_q [BUF_HW];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] w_wr_ptr1;
    logic [PW-1:0] w_rd_ptr1;

    assign w_wr_ptr1 = wr_ptr_q + PW'(1);
    assign w_rd_ptr1 = rd_ptr_q + PW'(1);

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(PopN_i);
        wr_ptr_d = wr_ptr_q + PW'(PushN_i);
        count_d  = count_q + CW'(PushN_i) - CW'(PopN_i);
        if (Flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge Clk_i) begin
        if (!Flush_i) begin
            if (PushN_i != 2'd0) begin
                mem_q[wr_ptr_q] <= PushData_i[15:0];
            end
            if (PushN_i == 2'd2) begin
                mem_q[w_wr_ptr1] <= PushData_i[31:16];
            end
        end
    end

    assign Count_o = count_q;
    assign Head0_o = mem_q[rd_ptr_q];
    assign Head1_o = mem_q[w_rd_ptr1];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_fetch_align : word fetch, halfword realignment, 16/32-bit issue       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module inst_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 4
) (
    input  logic        Clk_i,
    input  logic        Rst_i,
    input  logic        Redirect_i,
    input  logic [31:0] RedirectPC_i,
    output logic        MemReq_o,
    output logic [31:0] MemAddr_o,
    input  logic        MemAck_i,
    input  logic [31:0] MemRdata_i,
    output logic        InstValid_o,
    input  logic        InstReady_i,
    output logic [31:0] Inst_o,
    output logic [31:0] InstPC_o,
    output logic        Compressed_o
);
    import inst_fetch_align_pkg::*;

    localparam int CW = $clog2(BUF_HW) + 1;

    fetch_state_e  state_q;
    logic          mem_req_q;
    logic [31:0]   addr_q;
    logic [31:0]   redir_addr_q;
    logic          drop_lo_q;
    logic [31:0]   pc_q, pc_d;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_free;
    logic [15:0]   w_h0, w_h1;
    logic          w_is16;
    logic          w_avail;
    logic          w_fire;
    logic          w_accept;
    logic [1:0]    w_push_n, w_pop_n;
    logic [31:0]   w_swapped;
    logic [31:0]   w_push_data;
    logic [31:0]   w_target_word;
    logic          w_unused;

    assign w_unused      = RedirectPC_i[0];
    assign w_target_word = {RedirectPC_i[31:2], 2'b00};

    assign w_free   = CW'(BUF_HW) - w_count;
    assign w_is16   = (w_h0[1:0] != c_rvc_quad32);
    assign w_avail  = (w_count >= CW'(2)) || ((w_count != '0) && w_is16);

    assign InstValid_o  = w_avail && !Redirect_i;
    assign w_fire       = InstValid_o && InstReady_i;
    assign w_pop_n      = w_fire ? (w_is16 ? 2'd1 : 2'd2) : 2'd0;
    assign Inst_o       = InstValid_o ? (w_is16 ? {16'h0000, w_h0} : {w_h1, w_h0}) : 32'h0;
    assign Compressed_o = InstValid_o && w_is16;
    assign InstPC_o     = pc_q;

    // Only a live request's data is kept; a redirect in the ack cycle drops it.
    assign w_accept    = (state_q == ST_REQ) && MemAck_i && !Redirect_i;
    assign w_swapped   = byte_swap(MemRdata_i);
    assign w_push_n    = w_accept ? (drop_lo_q ? 2'd1 : 2'd2) : 2'd0;
    assign w_push_data = drop_lo_q ? {16'h0000, w_swapped[31:16]} : w_swapped;

    assign MemReq_o  = mem_req_q;
    assign MemAddr_o = addr_q;

    inst_fetch_align_hw_queue #(
        .BUF_HW (BUF_HW)
    ) u_queue (
        .Clk_i      (Clk_i),
        .Rst_i      (Rst_i),
        .Flush_i    (Redirect_i),
        .PushN_i    (w_push_n),
        .PushData_i (w_push_data),
        .PopN_i     (w_pop_n),
        .Count_o    (w_count),
        .Head0_o    (w_h0),
        .Head1_o    (w_h1)
    );

    // DISCARD keeps the stale address on the bus and parks the target aside.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            addr_q       <= RESET_PC;
            redir_addr_q <= RESET_PC;
            drop_lo_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Redirect_i) begin
                        addr_q    <= w_target_word;
                        drop_lo_q <= RedirectPC_i[1];
                        state_q   <= ST_REQ;
                        mem_req_q <= 1'b1;
                    end else if (w_free >= CW'(2)) begin
                        state_q   <= ST_REQ;
                        mem_req_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (MemAck_i && Redirect_i) begin
                        addr_q    <= w_target_word;
                        drop_lo_q <= RedirectPC_i[1];
                    end else if (MemAck_i) begin
                        addr_q    <= addr_q + 32'd4;
                        drop_lo_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end else if (Redirect_i) begin
                        redir_addr_q <= w_target_word;
                        drop_lo_q    <= RedirectPC_i[1];
                        state_q      <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (MemAck_i) begin
                        addr_q    <= Redirect_i ? w_target_word : redir_addr_q;
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        if (Redirect_i) begin
                            drop_lo_q <= RedirectPC_i[1];
                        end
                    end else if (Redirect_i) begin
                        redir_addr_q <= w_target_word;
                        drop_lo_q    <= RedirectPC_i[1];
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (Redirect_i) begin
            pc_d = {RedirectPC_i[31:1], 1'b0};
        end else if (w_fire) begin
            pc_d = pc_q + (w_is16 ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_fetch_align : scoreboard bench, instruction stream from memory map |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_inst_fetch_align;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    logic        clk;
    logic        Rst_i;
    logic        Redirect_i;
    logic [31:0] RedirectPC_i;
    logic        MemReq_o;
    logic [31:0] MemAddr_o;
    logic        MemAck_i;
    logic [31:0] MemRdata_i;
    logic        InstValid_o;
    logic        InstReady_i;
    logic [31:0] Inst_o;
    logic [31:0] InstPC_o;
    logic        Compressed_o;

    inst_fetch_align #(
        .RESET_PC (c_reset_pc),
        .BUF_HW   (4)
    ) dut (
        .Clk_i        (clk),
        .Rst_i        (Rst_i),
        .Redirect_i   (Redirect_i),
        .RedirectPC_i (RedirectPC_i),
        .MemReq_o     (MemReq_o),
        .MemAddr_o    (MemAddr_o),
        .MemAck_i     (MemAck_i),
        .MemRdata_i   (MemRdata_i),
        .InstValid_o  (InstValid_o),
        .InstReady_i  (InstReady_i),
        .Inst_o       (Inst_o),
        .InstPC_o     (InstPC_o),
        .Compressed_o (Compressed_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        comp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] imem [256];   // instruction words, aliased over pc[9:2]
    int          checks = 0;
    int          errors = 0;

    int unsigned max_lat   = 0;
    logic        hold_on   = 1'b0;
    logic        hold_all  = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    logic        force_ack = 1'b0;
    logic        stray_ack = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors so far %0d)", errors);
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] pc);
        logic [31:0] w;
        w = imem[pc[9:2]];
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Bus carries the byte at the lowest address in the top lane.
    function automatic logic [31:0] to_bus(input logic [31:0] w);
        logic [31:0] b;
        for (int i = 0; i < 4; i++) begin
            b[8*(3-i) +: 8] = w[8*i +: 8];
        end
        return b;
    endfunction

    task automatic push_stream(input logic [31:0] start);
        logic [31:0] pc;
        logic [15:0] h;
        exp_t        e;
        exp_q.delete();
        pc = {start[31:1], 1'b0};
        for (int i = 0; i < 96; i++) begin
            h    = hw_at(pc);
            e.pc = pc;
            if (h[1:0] != 2'b11) begin
                e.inst = {16'h0000, h};
                e.comp = 1'b1;
                pc     = pc + 32'd2;
            end else begin
                e.inst = {hw_at(pc + 32'd2), h};
                e.comp = 1'b0;
                pc     = pc + 32'd4;
            end
            exp_q.push_back(e);
        end
    endtask

    // Memory responder
    initial begin
        logic held;
        MemAck_i   = 1'b0;
        MemRdata_i = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            MemAck_i = 1'b0;
            if (stray_ack) begin
                MemAck_i   = 1'b1;
                MemRdata_i = 32'hDEAD_BEEF;
            end else if (MemReq_o && !Rst_i) begin
                held = hold_all || (hold_on && (MemAddr_o == hold_addr));
                if (held ? force_ack : ($urandom_range(0, max_lat) == 0)) begin
                    MemAck_i   = 1'b1;
                    MemRdata_i = to_bus(imem[MemAddr_o[9:2]]);
                    check32("mem_addr_align", {30'd0, MemAddr_o[1:0]}, 32'd0);
                end
            end
        end
    end

    // Monitor: every presented instruction must equal the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!Rst_i && InstValid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: got pc %h inst %h expected none", InstPC_o, Inst_o);
                end else begin
                    e = exp_q[0];
                    check32("inst_pc", InstPC_o, e.pc);
                    check32("inst", Inst_o, e.inst);
                    check32("compressed", {31'd0, Compressed_o}, {31'd0, e.comp});
                    if (InstReady_i) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic sync_reset();
        @(negedge clk);
        Rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        push_stream(c_reset_pc);
        Rst_i = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int          n;
        logic [31:0] raw;
        int          r;

        Rst_i        = 1'b1;
        Redirect_i   = 1'b0;
        RedirectPC_i = 32'h0;
        InstReady_i  = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        imem[0] = 32'h0000_0013;
        imem[1] = 32'h0000_0013;

        // Reset values
        @(posedge clk);
        #2;
        check32("rst_memreq",  {31'd0, MemReq_o}, 32'd0);
        check32("rst_memaddr", MemAddr_o, c_reset_pc);
        check32("rst_valid",   {31'd0, InstValid_o}, 32'd0);
        check32("rst_inst",    Inst_o, 32'd0);
        check32("rst_pc",      InstPC_o, c_reset_pc);
        check32("rst_comp",    {31'd0, Compressed_o}, 32'd0);

        // Two addi words, immediate ack
        @(negedge clk);
        push_stream(c_reset_pc);
        Rst_i       = 1'b0;
        InstReady_i = 1'b1;
        max_lat     = 0;
        run(20);

        // Mixed 16/32 with a straddling instruction
        imem[0] = 32'h0093_0001;
        imem[1] = 32'h0001_00A0;
        max_lat = 2;
        sync_reset();
        run(30);

        // Backpressure
        max_lat = 0;
        run(5);
        repeat (10) begin
            @(negedge clk);
            InstReady_i = 1'b0;
        end
        #2;
        check32("stall_memreq_off", {31'd0, MemReq_o}, 32'd0);
        check32("stall_valid_on",   {31'd0, InstValid_o}, 32'd1);
        @(negedge clk);
        InstReady_i = 1'b1;
        run(30);

        // Redirect to 0x102 while 0x8 is outstanding
        hold_on   = 1'b1;
        hold_addr = 32'h8;
        sync_reset();
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            #2;
            if (MemReq_o && MemAddr_o == 32'h8) break;
        end
        check32("wait_req_0x8", n, (n < 50) ? n : 50);
        if (n == 50) $display("FAIL wait_req_0x8: no request to 0x8 within 50 cycles");
        @(negedge clk);
        Redirect_i   = 1'b1;
        RedirectPC_i = 32'h102;
        push_stream(32'h102);
        @(negedge clk);
        Redirect_i = 1'b0;
        @(negedge clk);
        #2;
        check32("discard_req_held",  {31'd0, MemReq_o}, 32'd1);
        check32("discard_addr_held", MemAddr_o, 32'h8);
        hold_on = 1'b0;
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            #2;
            if (MemReq_o && MemAddr_o != 32'h8) break;
        end
        check32("redirect_addr", MemAddr_o, 32'h100);
        run(20);

        // Redirect in the same cycle as fire and ack
        InstReady_i = 1'b0;
        hold_on     = 1'b1;
        hold_addr   = 32'h4;
        sync_reset();
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            #2;
            if (MemReq_o && MemAddr_o == 32'h4 && InstValid_o) break;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL wait_same_cycle: setup not reached within 50 cycles");
        end
        @(negedge clk);
        InstReady_i  = 1'b1;
        Redirect_i   = 1'b1;
        RedirectPC_i = 32'h0000_02E6;
        force_ack    = 1'b1;
        push_stream(32'h0000_02E6);
        #2;
        check32("redir_valid_forced", {31'd0, InstValid_o}, 32'd0);
        @(posedge clk);
        #1;
        check32("redir_pc", InstPC_o, 32'h0000_02E6);
        @(negedge clk);
        Redirect_i = 1'b0;
        force_ack  = 1'b0;
        hold_on    = 1'b0;
        run(20);

        // Asynchronous reset during a held request, then a stray ack while IDLE
        hold_all = 1'b1;
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            #2;
            if (MemReq_o) break;
        end
        @(posedge clk);
        #3;
        Rst_i = 1'b1;
        exp_q.delete();
        #1;
        check32("arst_memreq",  {31'd0, MemReq_o}, 32'd0);
        check32("arst_memaddr", MemAddr_o, c_reset_pc);
        check32("arst_valid",   {31'd0, InstValid_o}, 32'd0);
        check32("arst_inst",    Inst_o, 32'd0);
        check32("arst_pc",      InstPC_o, c_reset_pc);
        check32("arst_comp",    {31'd0, Compressed_o}, 32'd0);
        @(negedge clk);
        hold_all  = 1'b0;
        stray_ack = 1'b1;
        push_stream(c_reset_pc);
        Rst_i = 1'b0;
        @(negedge clk);
        stray_ack = 1'b0;
        #2;
        check32("restart_req",  {31'd0, MemReq_o}, 32'd1);
        check32("restart_addr", MemAddr_o, c_reset_pc);
        run(20);

        // Random traffic with redirects, including the address wrap
        for (int ph = 0; ph < 6; ph++) begin
            max_lat = $urandom_range(0, 3);
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                InstReady_i = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 19) == 0) begin
                    r = $urandom_range(0, 9);
                    if (r == 0)      raw = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    else if (r == 1) raw = $urandom;
                    else             raw = 32'($urandom_range(0, 32'h3FF));
                    Redirect_i   = 1'b1;
                    RedirectPC_i = raw;
                    push_stream(raw);
                end else begin
                    Redirect_i = 1'b0;
                end
            end
        end
        @(negedge clk);
        Redirect_i  = 1'b0;
        InstReady_i = 1'b1;
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
